// File: rtl/rv32im_pc_unit.sv
// Program-counter unit: next-PC selection with stall/fetch-ready handshake,
// a one-deep buffered redirect, trap override and misaligned-target rejection.
module rv32im_pc_unit #(
  parameter int          PC_WIDTH = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_INC   = 4,
  parameter int          IALIGN   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                stall_i,
  input  logic                redirect_valid_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  input  logic                trap_valid_i,
  input  logic [PC_WIDTH-1:0] trap_vector_i,
  input  logic                fetch_ready_i,
  output logic                fetch_valid_o,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [PC_WIDTH-1:0] pc_plus_o,
  output logic                redirect_pending_o,
  output logic                misalign_o,
  output logic [PC_WIDTH-1:0] misalign_addr_o,
  output logic [1:0]          state_o
);

  // Handshake: a fetch is transferred at a falling edge where
  // fetch_valid_o & fetch_ready_i; pc_o is held stable until then.
  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  localparam logic [PC_WIDTH-1:0] RST_PC     = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(IALIGN - 1);
  localparam logic [PC_WIDTH-1:0] INC        = PC_WIDTH'(PC_INC);

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pend_q, pend_d;
  logic                mis_q, mis_d;
  logic [PC_WIDTH-1:0] mis_addr_q, mis_addr_d;
  logic                advance;
  logic                redir_misaligned;

  assign advance          = fetch_ready_i & ~stall_i;
  assign redir_misaligned = |(redirect_pc_i & ALIGN_MASK);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;
    if (trap_valid_i) begin
      pc_d    = trap_vector_i & ~ALIGN_MASK;
      pend_d  = '0;
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_BOOT: state_d = S_RUN;
        S_RUN, S_PEND: begin
          if (redirect_valid_i) begin
            // A misaligned target leaves pc, state and any buffered target untouched.
            if (redir_misaligned) begin
              mis_d      = 1'b1;
              mis_addr_d = redirect_pc_i;
            end else if (advance) begin
              pc_d    = redirect_pc_i;
              pend_d  = '0;
              state_d = S_RUN;
            end else begin
              pend_d  = redirect_pc_i;
              state_d = S_PEND;
            end
          end else if (advance) begin
            if (state_q == S_PEND) begin
              pc_d   = pend_q;
              pend_d = '0;
            end else begin
              pc_d = pc_q + INC;
            end
            state_d = S_RUN;
          end
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RST_PC;
      pend_q     <= '0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  assign fetch_valid_o      = (state_q != S_BOOT);
  assign pc_o               = pc_q;
  assign pc_plus_o          = pc_q + INC;
  assign redirect_pending_o = (state_q == S_PEND);
  assign misalign_o         = mis_q;
  assign misalign_addr_o    = mis_addr_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_rv32im_pc_unit.sv
// Bench for rv32im_pc_unit: two instances (IALIGN=4 and IALIGN=2) share stimulus
// and are checked every cycle against a rule-level model plus literal expectations.
module tb_rv32im_pc_unit;

  logic        clk;
  logic        reset_n;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        trap_valid_i;
  logic [31:0] trap_vector_i;
  logic        fetch_ready_i;

  logic        fv4, pend4, mis4, fv2, pend2, mis2;
  logic [31:0] pc4, pcp4, ma4, pc2, pcp2, ma2;
  logic [1:0]  st4, st2;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    bit          running;
    bit          pend;
    logic [31:0] pend_tgt;
    bit          mis;
    logic [31:0] mis_addr;
  } model_t;

  model_t m4, m2;

  rv32im_pc_unit #(.PC_WIDTH(32), .RESET_PC(32'h0), .PC_INC(4), .IALIGN(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .trap_valid_i(trap_valid_i), .trap_vector_i(trap_vector_i),
    .fetch_ready_i(fetch_ready_i), .fetch_valid_o(fv4), .pc_o(pc4),
    .pc_plus_o(pcp4), .redirect_pending_o(pend4), .misalign_o(mis4),
    .misalign_addr_o(ma4), .state_o(st4)
  );

  rv32im_pc_unit #(.PC_WIDTH(32), .RESET_PC(32'h0), .PC_INC(4), .IALIGN(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .trap_valid_i(trap_valid_i), .trap_vector_i(trap_vector_i),
    .fetch_ready_i(fetch_ready_i), .fetch_valid_o(fv2), .pc_o(pc2),
    .pc_plus_o(pcp2), .redirect_pending_o(pend2), .misalign_o(mis2),
    .misalign_addr_o(ma2), .state_o(st2)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic model_t model_reset();
    model_t r;
    r.pc = 32'h0; r.running = 0; r.pend = 0; r.pend_tgt = 32'h0;
    r.mis = 0; r.mis_addr = 32'h0;
    return r;
  endfunction

  function automatic model_t model_next(model_t s, int ialign, bit st, bit rv,
                                        logic [31:0] rpc, bit tr, logic [31:0] tv, bit rdy);
    model_t n;
    logic [31:0] a;
    bit adv;
    n = s;
    n.mis = 0;
    a = 32'(ialign);
    adv = rdy && !st;
    if (tr) begin
      n.pc = tv - (tv % a);
      n.running = 1;
      n.pend = 0;
    end else if (!s.running) begin
      n.running = 1;
    end else if (rv) begin
      if ((rpc % a) != 0) begin
        n.mis = 1;
        n.mis_addr = rpc;
      end else if (adv) begin
        n.pc = rpc;
        n.pend = 0;
      end else begin
        n.pend = 1;
        n.pend_tgt = rpc;
      end
    end else if (adv) begin
      if (s.pend) begin
        n.pc = s.pend_tgt;
        n.pend = 0;
      end else begin
        n.pc = s.pc + 32'd4;
      end
    end
    return n;
  endfunction

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m4 = model_reset();
      m2 = model_reset();
    end else begin
      m4 = model_next(m4, 4, stall_i, redirect_valid_i, redirect_pc_i,
                      trap_valid_i, trap_vector_i, fetch_ready_i);
      m2 = model_next(m2, 2, stall_i, redirect_valid_i, redirect_pc_i,
                      trap_valid_i, trap_vector_i, fetch_ready_i);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset_n) begin
      check("a4.fetch_valid", 32'(fv4),   32'(m4.running));
      check("a4.pc",          pc4,        m4.pc);
      check("a4.pc_plus",     pcp4,       m4.pc + 32'd4);
      check("a4.pending",     32'(pend4), 32'(m4.pend));
      check("a4.misalign",    32'(mis4),  32'(m4.mis));
      check("a4.mis_addr",    ma4,        m4.mis_addr);
      check("a2.fetch_valid", 32'(fv2),   32'(m2.running));
      check("a2.pc",          pc2,        m2.pc);
      check("a2.pc_plus",     pcp2,       m2.pc + 32'd4);
      check("a2.pending",     32'(pend2), 32'(m2.pend));
      check("a2.misalign",    32'(mis2),  32'(m2.mis));
      check("a2.mis_addr",    ma2,        m2.mis_addr);
    end
  end

  // ---------------- driver ----------------
  task automatic step(bit st, bit rv, logic [31:0] rpc, bit tr, logic [31:0] tv, bit rdy);
    stall_i          = st;
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
    trap_valid_i     = tr;
    trap_vector_i    = tv;
    fetch_ready_i    = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, 32'h0, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    stall_i = 0; redirect_valid_i = 0; redirect_pc_i = 0;
    trap_valid_i = 0; trap_vector_i = 0; fetch_ready_i = 1;
    @(posedge clk); #1;
    check("rst.pc",       pc4, 32'h0);
    check("rst.pc_plus",  pcp4, 32'h4);
    check("rst.valid",    32'(fv4), 32'h0);
    check("rst.pending",  32'(pend4), 32'h0);
    check("rst.misalign", 32'(mis4), 32'h0);
    check("rst.mis_addr", ma4, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("boot.valid", 32'(fv4), 32'h0);

    // Boot edge, then sequential fetch
    idle();
    check("seq0.pc", pc4, 32'h0);
    check("seq0.valid", 32'(fv4), 32'h1);
    idle(); check("seq1.pc", pc4, 32'h4);
    idle(); check("seq2.pc", pc4, 32'h8);
    idle(); check("seq3.pc", pc4, 32'hC);
    check("model.seq3", m4.pc, 32'hC);
    idle(); check("seq4.pc", pc4, 32'h10);

    // Stall with a buffered redirect
    step(1, 1, 32'h200, 0, 32'h0, 1);
    check("stall1.pc", pc4, 32'h10);
    check("stall1.pend", 32'(pend4), 32'h1);
    step(1, 0, 32'h0, 0, 32'h0, 1);
    step(1, 0, 32'h0, 0, 32'h0, 1);
    check("stall3.pc", pc4, 32'h10);
    check("model.stall3", 32'(m4.pend), 32'h1);
    idle();
    check("unstall.pc", pc4, 32'h200);
    check("unstall.pend", 32'(pend4), 32'h0);
    idle(); check("after.pc", pc4, 32'h204);

    // Back-to-back redirects while fetch is not ready
    step(0, 1, 32'h100, 0, 32'h0, 0);
    step(0, 1, 32'h300, 0, 32'h0, 0);
    check("b2b.hold", pc4, 32'h204);
    idle();
    check("b2b.pc", pc4, 32'h300);
    check("model.b2b", m4.pc, 32'h300);
    idle(); check("b2b.next", pc4, 32'h304);

    // Trap during stall overrides pending redirect
    step(1, 1, 32'h400, 0, 32'h0, 1);
    check("trap.pend_before", 32'(pend4), 32'h1);
    step(1, 0, 32'h0, 1, 32'h8000_0003, 0);
    check("trap.pc4", pc4, 32'h8000_0000);
    check("trap.pc2", pc2, 32'h8000_0002);
    check("trap.pend", 32'(pend4), 32'h0);
    check("model.trap2", m2.pc, 32'h8000_0002);
    idle(); check("trap.next", pc4, 32'h8000_0004);

    // Misaligned redirect: rejected for IALIGN=4, accepted for IALIGN=2
    step(0, 1, 32'h102, 0, 32'h0, 1);
    check("mis.pulse", 32'(mis4), 32'h1);
    check("mis.addr", ma4, 32'h102);
    check("mis.pc4", pc4, 32'h8000_0004);
    check("mis.pc2", pc2, 32'h102);
    check("mis.none2", 32'(mis2), 32'h0);
    idle();
    check("mis.drop", 32'(mis4), 32'h0);
    check("mis.hold", ma4, 32'h102);
    check("mis.pc2next", pc2, 32'h106);

    // Misaligned redirect during stall while pending: pending kept
    step(1, 1, 32'h600, 0, 32'h0, 1);
    step(1, 1, 32'h601, 0, 32'h0, 1);
    check("mispend.pulse2", 32'(mis2), 32'h1);
    check("mispend.pend", 32'(pend4), 32'h1);
    idle(); check("mispend.pc", pc4, 32'h600);

    // Trap beats a simultaneous misaligned redirect
    step(0, 1, 32'h703, 1, 32'h0000_0084, 1);
    check("trapmis.pc", pc4, 32'h84);
    check("trapmis.nopulse", 32'(mis4), 32'h0);

    // Wrap-around
    step(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1);
    check("wrap.pc", pc4, 32'hFFFF_FFFC);
    check("wrap.plus", pcp4, 32'h0);
    idle(); check("wrap.next", pc4, 32'h0);

    // Asynchronous reset in PEND
    step(1, 1, 32'h500, 0, 32'h0, 1);
    check("arst.pend_before", 32'(pend4), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("arst.pc", pc4, 32'h0);
    check("arst.valid", 32'(fv4), 32'h0);
    check("arst.pend", 32'(pend4), 32'h0);
    check("arst.pend2", 32'(pend2), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("arst.boot_valid", 32'(fv2), 32'h0);

    // Trap honoured in BOOT
    step(0, 0, 32'h0, 1, 32'h0000_0043, 1);
    check("boottrap.pc4", pc4, 32'h40);
    check("boottrap.pc2", pc2, 32'h42);
    check("boottrap.valid", 32'(fv4), 32'h1);
    idle();
    check("boottrap.next4", pc4, 32'h44);
    check("boottrap.next2", pc2, 32'h46);

    // Redirect ignored in BOOT
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(0, 1, 32'h900, 0, 32'h0, 1);
    check("bootredir.pc", pc4, 32'h0);
    idle(); check("bootredir.next", pc4, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
